alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//   Shares the single 64-bit combinational ALU between two requesters (req0, req1).
//   - Arbitrates round-robin and registers one operation.
//   - Holds the ALU inputs stable for a per-opcode number of cycles, which makes MUL/DIV/REM
//     multicycle paths.
//   - Returns the result with the requester id on one shared response channel.
//   Sits between the decode/issue logic and the ALU instance.
// PARAMETERS
//   MULDIV_CYCLES  4  ALU cycles allowed for MUL(3), DIV(4), REM(8); legal range >=1
//   SIMPLE_CYCLES  1  ALU cycles allowed for all other opcodes; legal range >=1
// PORTS
//   clk          in   1   clock; all logic on posedge
//   reset        in   1   synchronous, active-high
//   req0_valid   in   1   requester 0 has an operation
//   req0_ready   out  1   requester 0 operation accepted this cycle
//   req0_opcode  in   4   ALU opcode: ADD=1 SUB=2 MUL=3 DIV=4 XOR=5 AND=6 OR=7 REM=8 NOT=9
//   req0_a       in   64  operand 1
//   req0_b       in   64  operand 2
//   req1_*       --   --  same set as req0_*, for requester 1
//   resp_valid   out  1   result available
//   resp_ready   in   1   consumer takes result
//   resp_id      out  1   0=req0, 1=req1
//   resp_result  out  64  operation result
//   resp_dz      out  1   DIV/REM with operand 2 == 0
//   alu_opcode   out  4   to ALU opcode
//   alu_value1   out  64  to ALU value1
//   alu_value2   out  64  to ALU value2
//   alu_result   in   64  from ALU result
// BEHAVIOUR
//   - Reset: state=IDLE, last_grant=1, all outputs 0. An in-flight op is dropped with no response.
//   - States: IDLE -> EXEC -> RESP -> IDLE. The block holds one op at a time; there is no bypass.
//   - IDLE grant (combinational):
//     - If only reqX_valid is high, grant X.
//     - If both are valid, grant the requester != last_grant.
//     - reqX_ready = (state==IDLE) && granted X. Ready is never high outside IDLE and never high
//       for both requesters.
//   - Accept on edge k (valid&&ready):
//     - Register opcode, a, b and id; last_grant<=id.
//     - cnt <= N-1, where N=MULDIV_CYCLES for opcodes 3/4/8 and SIMPLE_CYCLES otherwise.
//     - state<=EXEC.
//   - alu_opcode/alu_value1/alu_value2 are driven only from the op registers.
//     - They are stable from edge k until the next accept.
//     - They are not cleared in RESP or IDLE.
//   - EXEC: cnt decrements each cycle. At the edge where cnt==0, resp_result<=alu_result and
//     state<=RESP. resp_valid therefore asserts at edge k+N.
//   - Divide by zero (opcode 4 or 8 with b==0):
//     - alu_result is ignored; resp_dz=1.
//     - DIV gives 64'hFFFF_FFFF_FFFF_FFFF; REM gives a.
//     - Latency is unchanged (N=MULDIV_CYCLES).
//   - Undefined opcodes (0, 10-15) are passed to the ALU unchanged with SIMPLE_CYCLES latency.
//     The result is whatever the ALU returns (value1). resp_dz=0.
//   - RESP: resp_valid, resp_id, resp_result and resp_dz are held stable until resp_ready.
//     - On resp_valid&&resp_ready: state<=IDLE, resp_valid<=0.
//     - The next accept is earliest in the following cycle.
//     - resp_id, resp_result and resp_dz keep their last values after the handshake.
//   - Requesters must hold their valid and fields until ready. The block samples fields only on
//     the accepting edge.
//   - Throughput: one op per N+2 cycles at best (accept, N exec, response).
// TESTING
//   1. Reset held 3 cycles with both reqs valid -> no ready, resp_valid=0, alu_* =0.
//   2. req0 ADD a=5 b=7, resp_ready=1 -> resp_valid at edge k+1, result=12, id=0, dz=0.
//   3. req1 MUL a=6 b=7 (MULDIV_CYCLES=4) -> alu_* stable 4 cycles; result=42 at edge k+4, id=1.
//   4. Both valid every cycle, resp_ready=1 -> grants alternate 0,1,0,1; first grant is req0.
//   5. req0 DIV a=9 b=0 -> result=all ones, dz=1; req0 REM a=9 b=0 -> result=9, dz=1.
//   6. resp_ready=0 for 5 cycles in RESP -> outputs held, req ready stays 0.
//      Then assert reset during EXEC -> IDLE next cycle, no response emitted.

Source files
------------

// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
//   Shares one 64-bit combinational ALU between two requesters. One operation
//   is accepted at a time. The requesters are arbitrated round-robin. The ALU
//   inputs are held stable for a per-opcode number of cycles, so MUL/DIV/REM
//   can be timed as multicycle paths. The result goes back on one shared
//   response channel together with the requester id.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   req{0,1}_valid/ready           request handshake per requester
//   req{0,1}_opcode/a/b            operation fields (sampled on accept only)
//   resp_valid/ready               response handshake
//   resp_id/result/dz              requester id, result, divide-by-zero flag
//   alu_opcode/value1/value2       held operands driven to the ALU
//   alu_result                     combinational result from the ALU
// -----------------------------------------------------------------------------
module alu_sched #(
  parameter int MULDIV_CYCLES = 4,
  parameter int SIMPLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_opcode,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_opcode,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_result,
  output logic        resp_dz,
  output logic [3:0]  alu_opcode,
  output logic [63:0] alu_value1,
  output logic [63:0] alu_value2,
  input  logic [63:0] alu_result
);

  localparam int MAX_N = (MULDIV_CYCLES > SIMPLE_CYCLES) ? MULDIV_CYCLES : SIMPLE_CYCLES;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_REM = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_opcode;
  logic [63:0]      r_a;
  logic [63:0]      r_b;
  logic             r_id;
  logic [63:0]      r_resp_result;
  logic             r_resp_dz;

  logic             w_any_valid;
  logic             w_grant_id;
  logic             w_accept;
  logic [3:0]       w_sel_opcode;
  logic [63:0]      w_sel_a;
  logic [63:0]      w_sel_b;
  logic             w_sel_muldiv;
  logic [CNT_W-1:0] w_cnt_init;
  logic             w_exec_done;
  logic             w_is_div;
  logic             w_is_rem;
  logic             w_dz;
  logic [63:0]      w_result;

  // ---------------------------------------------------------------------------
  // Grant: a lone requester always wins; with both pending, the one that did
  // not win last time goes next. Ready is suppressed while reset is asserted
  // so nothing appears accepted on a reset edge.
  // ---------------------------------------------------------------------------
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept    = (r_state == IDLE) && !reset && w_any_valid;
  assign req0_ready  = w_accept && !w_grant_id;
  assign req1_ready  = w_accept &&  w_grant_id;

  assign w_sel_opcode = w_grant_id ? req1_opcode : req0_opcode;
  assign w_sel_a      = w_grant_id ? req1_a      : req0_a;
  assign w_sel_b      = w_grant_id ? req1_b      : req0_b;
  assign w_sel_muldiv = (w_sel_opcode == OP_MUL) || (w_sel_opcode == OP_DIV) ||
                        (w_sel_opcode == OP_REM);
  // The counter counts the remaining cycles after the first, so N-1 is loaded.
  assign w_cnt_init   = w_sel_muldiv ? CNT_W'(MULDIV_CYCLES - 1) : CNT_W'(SIMPLE_CYCLES - 1);

  assign w_exec_done  = (r_state == EXEC) && (r_cnt == '0);

  // A zero divisor overrides whatever the ALU produces.
  assign w_is_div = (r_opcode == OP_DIV);
  assign w_is_rem = (r_opcode == OP_REM);
  assign w_dz     = (w_is_div || w_is_rem) && (r_b == 64'd0);
  assign w_result = !w_dz    ? alu_result :
                    w_is_div ? {64{1'b1}} : r_a;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_next = EXEC;
      EXEC:    if (w_exec_done) w_state_next = RESP;
      RESP:    if (resp_ready)  w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operation and response registers. The op registers feed the ALU directly
  // and only change on an accept, so the ALU inputs stay put through EXEC,
  // RESP and the following IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant  <= 1'b1;
      r_cnt         <= '0;
      r_opcode      <= 4'd0;
      r_a           <= 64'd0;
      r_b           <= 64'd0;
      r_id          <= 1'b0;
      r_resp_result <= 64'd0;
      r_resp_dz     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opcode     <= w_sel_opcode;
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
        r_cnt        <= w_cnt_init;
      end else if (r_state == EXEC) begin
        if (r_cnt == '0) begin
          r_resp_result <= w_result;
          r_resp_dz     <= w_dz;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  // resp_id simply mirrors the id of the op that produced the held result;
  // it only changes on the next accept, after the previous handshake.
  assign resp_valid  = (r_state == RESP);
  assign resp_id     = r_id;
  assign resp_result = r_resp_result;
  assign resp_dz     = r_resp_dz;

  assign alu_opcode  = r_opcode;
  assign alu_value1  = r_a;
  assign alu_value2  = r_b;

endmodule

// File: tb/tb_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_sched
//   Self-checking bench for alu_sched. Directed steps plus randomized
//   operations; expected results, latencies and grants come from a
//   transaction-level model (opcode arithmetic and round-robin turn-taking).
// -----------------------------------------------------------------------------
module tb_alu_sched;

  localparam int MD = 4;
  localparam int SC = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_dz;
  logic [63:0] resp_result;
  logic [3:0]  alu_opcode;
  logic [63:0] alu_value1, alu_value2, alu_result;

  int   n_total = 0;
  int   n_pass  = 0;
  logic tb_last;

  always #5 clk = ~clk;

  alu_sched #(.MULDIV_CYCLES(MD), .SIMPLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_dz(resp_dz),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_result(alu_result)
  );

  // Stand-in ALU. A zero divisor yields a junk value the scheduler must ignore.
  always_comb begin
    alu_result = alu_value1;
    case (alu_opcode)
      4'd1: alu_result = alu_value1 + alu_value2;
      4'd2: alu_result = alu_value1 - alu_value2;
      4'd3: alu_result = alu_value1 * alu_value2;
      4'd4: alu_result = (alu_value2 == 0) ? 64'h0BAD_0BAD_0BAD_0BAD : alu_value1 / alu_value2;
      4'd5: alu_result = alu_value1 ^ alu_value2;
      4'd6: alu_result = alu_value1 & alu_value2;
      4'd7: alu_result = alu_value1 | alu_value2;
      4'd8: alu_result = (alu_value2 == 0) ? 64'h0BAD_0BAD_0BAD_0BAD : alu_value1 % alu_value2;
      4'd9: alu_result = ~alu_value1;
      default: alu_result = alu_value1;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected latency in cycles for an opcode.
  function automatic int lat_of(input logic [3:0] op);
    return (op == 4'd3 || op == 4'd4 || op == 4'd8) ? MD : SC;
  endfunction

  // Expected {dz, result} for an operation.
  function automatic logic [64:0] ref_op(input logic [3:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    case (op)
      4'd1: return {1'b0, a + b};
      4'd2: return {1'b0, a - b};
      4'd3: return {1'b0, a * b};
      4'd4: return (b == 0) ? {1'b1, {64{1'b1}}} : {1'b0, a / b};
      4'd5: return {1'b0, a ^ b};
      4'd6: return {1'b0, a & b};
      4'd7: return {1'b0, a | b};
      4'd8: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
      4'd9: return {1'b0, ~a};
      default: return {1'b0, a};
    endcase
  endfunction

  task automatic set_req(input int id, input logic v, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    if (id == 0) begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic rand_req(input int id);
    logic [3:0]  op;
    logic [63:0] a, b;
    op = 4'($urandom_range(0, 15));
    a  = {$urandom, $urandom};
    b  = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'($urandom_range(0, 1) * $urandom), $urandom};
    set_req(id, 1'b1, op, a, b);
  endtask

  // One full transaction, entered at a negedge with requests already driven
  // and the scheduler idle. Returns at the negedge after the response
  // handshake. keep: the winner presents a fresh random op after acceptance.
  task automatic run_txn(input int hold, input bit keep);
    int          g, n;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic [64:0] exp;
    #1;
    g = (req0_valid && req1_valid) ? (tb_last ? 0 : 1) : (req1_valid ? 1 : 0);
    chk("ready0", req0_ready, g == 0);
    chk("ready1", req1_ready, g == 1);
    op  = (g == 0) ? req0_opcode : req1_opcode;
    a   = (g == 0) ? req0_a      : req1_a;
    b   = (g == 0) ? req0_b      : req1_b;
    n   = lat_of(op);
    exp = ref_op(op, a, b);
    @(posedge clk);
    tb_last = g[0];
    @(negedge clk);
    if (keep) rand_req(g);
    else if (g == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("exec_resp_valid", resp_valid, 0);
      chk("exec_ready", {req0_ready, req1_ready}, 0);
      chk("alu_opcode", alu_opcode, op);
      chk("alu_value1", alu_value1, a);
      chk("alu_value2", alu_value2, b);
    end
    @(negedge clk); #1;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, g);
    chk("resp_result", resp_result, exp[63:0]);
    chk("resp_dz", resp_dz, exp[64]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_result", resp_result, exp[63:0]);
      chk("hold_ready", {req0_ready, req1_ready}, 0);
    end
    resp_ready = 1'b1;
    $display("txn id=%0d op=%0d a=%h b=%h lat=%0d exp=%h dz=%0d got=%h", g, op, a, b, n,
             exp[63:0], exp[64], resp_result);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("post_resp_valid", resp_valid, 0);
    chk("post_resp_result", resp_result, exp[63:0]);
    chk("post_alu_value1", alu_value1, a);
  endtask

  initial begin
    reset = 1'b1;
    resp_ready = 1'b0;
    tb_last = 1'b1;
    set_req(0, 1'b1, 4'd1, 64'd1, 64'd2);
    set_req(1, 1'b1, 4'd2, 64'd3, 64'd4);

    // Reset held with both requests pending: nothing accepted, outputs zero.
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_alu_opcode", alu_opcode, 0);
      chk("rst_alu_value1", alu_value1, 0);
      chk("rst_alu_value2", alu_value2, 0);
    end
    reset = 1'b0;
    set_req(0, 1'b0, 4'd0, 64'd0, 64'd0);
    set_req(1, 1'b0, 4'd0, 64'd0, 64'd0);
    @(negedge clk); #1;
    chk("idle_resp_valid", resp_valid, 0);

    // Simple op, single-cycle latency.
    set_req(0, 1'b1, 4'd1, 64'd5, 64'd7);
    run_txn(0, 1'b0);
    // Multicycle op from requester 1.
    set_req(1, 1'b1, 4'd3, 64'd6, 64'd7);
    run_txn(0, 1'b0);
    // Divide and remainder by zero.
    set_req(0, 1'b1, 4'd4, 64'd9, 64'd0);
    run_txn(0, 1'b0);
    set_req(0, 1'b1, 4'd8, 64'd9, 64'd0);
    run_txn(0, 1'b0);
    // Undefined opcode returns value1 with simple latency.
    set_req(0, 1'b1, 4'd12, 64'h1234, 64'h5678);
    run_txn(0, 1'b0);

    // Both requesters always pending: grants must alternate.
    rand_req(0);
    rand_req(1);
    for (int t = 0; t < 24; t++) run_txn($urandom_range(0, 2), 1'b1);

    // Random pending patterns; a pending requester keeps its op.
    for (int t = 0; t < 24; t++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) rand_req(0);
      if (!req1_valid && (!req0_valid || $urandom_range(0, 1) == 1)) rand_req(1);
      run_txn($urandom_range(0, 1), 1'b0);
    end
    set_req(0, 1'b0, 4'd0, 64'd0, 64'd0);
    set_req(1, 1'b0, 4'd0, 64'd0, 64'd0);

    // Consumer stalls five cycles in RESP.
    set_req(1, 1'b1, 4'd5, 64'hF0F0, 64'h0FF0);
    run_txn(5, 1'b0);

    // Reset during EXEC drops the op: no response afterwards.
    set_req(0, 1'b1, 4'd3, 64'd11, 64'd13);
    #1;
    chk("pre_rst_ready0", req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tb_last = 1'b1;
    #1;
    chk("rst_exec_alu_opcode", alu_opcode, 0);
    repeat (MD + 2) begin
      @(negedge clk); #1;
      chk("rst_exec_no_resp", resp_valid, 0);
    end
    // After reset the first contested grant goes to requester 0.
    set_req(0, 1'b1, 4'd2, 64'd100, 64'd1);
    set_req(1, 1'b1, 4'd7, 64'd8, 64'd1);
    run_txn(0, 1'b0);
    run_txn(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
